universal_nbit_register: RTL and testbench
==========================================

Name: universal_nbit_register

Overview:
- Parametrised successor to the team's plain N-bit enable register.
- Adds masked parallel load, serial shift/rotate in both directions, increment/decrement counting, and carry/zero status flags.
- Used as a general-purpose datapath register in accumulator, shifter and counter slots, so those functions do not need separate blocks.
- Single clock domain; all state updates on the rising edge of clk.

Parameters:
- N, 8, data width in bits; legal range 2..64.
- RESET_VALUE, 0, value of the data register after reset; truncated to N bits.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- enable  input  1  operation qualifier; when low the register holds
- mode  input  3  operation select (encoding below)
- data_in  input  N  parallel load data
- load_mask  input  N  per-bit write enable for LOAD; 1 = bit written
- serial_in  input  1  bit shifted in on SHL/SHR
- data_out  output  N  current register contents
- carry_out  output  1  registered status from the last enabled operation
- zero  output  1  high when data_out == 0 (combinational from the register)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset, sampled only on the rising edge of clk.
- Reset:
  - data_out = RESET_VALUE; carry_out = 0.
  - zero = 1 exactly when RESET_VALUE == 0.
  - Reset has priority over enable and mode.
  - Reset asserted mid-sequence (e.g. during counting) discards the operation in that cycle.
- enable = 0: data_out holds; carry_out is cleared to 0 on that edge.
- Latency: every enabled operation updates data_out and carry_out on the same rising edge. Results are visible one cycle after mode/enable are sampled.
- mode encoding, applied when enable = 1:
  - 000 HOLD: data unchanged; carry_out <= 0.
  - 001 LOAD: for each bit i, data[i] <= load_mask[i] ? data_in[i] : data[i]. carry_out <= 0. An all-zero mask behaves as HOLD; an all-ones mask is a full load.
  - 010 SHL: data <= {data[N-2:0], serial_in}; carry_out <= old data[N-1].
  - 011 SHR: data <= {serial_in, data[N-1:1]}; carry_out <= old data[0].
  - 100 ROL: data <= {data[N-2:0], data[N-1]}; carry_out <= old data[N-1].
  - 101 ROR: data <= {data[0], data[N-1:1]}; carry_out <= old data[0].
  - 110 INC: data <= data + 1, modulo 2^N; carry_out <= 1 only when old data was all ones (wrap to 0).
  - 111 DEC: data <= data - 1, modulo 2^N; carry_out <= 1 only when old data was 0 (wrap to all ones).
- Arithmetic: unsigned N-bit. No saturation; wrap-around is always signalled through carry_out.
- carry_out is a one-cycle pulse per qualifying operation. Consecutive wrapping operations produce carry_out high on each of those cycles.
- zero is combinational from the register only, not from inputs, so it is glitch-free relative to clk.
- serial_in is ignored in every mode except SHL and SHR. load_mask is ignored outside LOAD.
- No X propagation: an undefined mode is impossible because all 8 codes are defined.

Test Plan:
- Reset: N=8, RESET_VALUE=8'hA5, assert reset for 2 cycles with enable=1, mode=INC -> data_out=A5, carry_out=0, zero=0. Repeat with RESET_VALUE=0 -> zero=1.
- Masked load: data=8'h00, LOAD data_in=8'hFF, load_mask=8'h0F -> data_out=0F, carry_out=0. Then mask=8'h00 with data_in=8'h00 -> data_out stays 0F.
- Shifts: data=8'h81.
  - SHL serial_in=0 -> 02, carry_out=1.
  - SHR serial_in=1 -> 81, carry_out=0.
  - ROR -> C0, carry_out=1.
  - ROL -> 81, carry_out=1.
- Wrap: data=8'hFE, INC x2 -> FF (carry 0), then 00 (carry 1, zero 1). DEC from 00 -> FF, carry_out=1.
- Enable/hold: data=8'h3C, enable=0 with mode=INC for 3 cycles -> data_out=3C throughout, carry_out=0. Reassert enable -> 3D.
- Reset mid-count: INC every cycle from 00, assert reset at the cycle data=05 -> next edge data_out=RESET_VALUE, carry_out=0, and counting resumes from RESET_VALUE after release.

Source files
------------

// File: rtl/universal_nbit_register.sv
// General-purpose N-bit datapath register supporting masked load, shift/rotate and inc/dec.
// It also provides a registered carry pulse and a combinational zero flag.
module universal_nbit_register #(
   parameter int unsigned N           = 8,
   parameter logic [63:0] RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [2:0]   mode,
   input  logic [N-1:0] data_in,
   input  logic [N-1:0] load_mask,
   input  logic         serial_in,
   output logic [N-1:0] data_out,
   output logic         carry_out,
   output logic         zero
);

   typedef enum logic [2:0] {
      ModeHold = 3'b000,
      ModeLoad = 3'b001,
      ModeShl  = 3'b010,
      ModeShr  = 3'b011,
      ModeRol  = 3'b100,
      ModeRor  = 3'b101,
      ModeInc  = 3'b110,
      ModeDec  = 3'b111
   } mode_e;

   localparam logic [N-1:0] ResetVal = RESET_VALUE[N-1:0];
   localparam logic [N-1:0] One      = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] data_q, data_d;
   logic         carry_q, carry_d;
   mode_e        mode_sel;

   assign mode_sel = mode_e'(mode);

   always_comb begin
      data_d  = data_q;
      carry_d = 1'b0;
      if (enable) begin
         unique case (mode_sel)
            ModeHold: data_d = data_q;
            ModeLoad: data_d = (data_in & load_mask) | (data_q & ~load_mask);
            ModeShl: begin
               data_d  = {data_q[N-2:0], serial_in};
               carry_d = data_q[N-1];
            end
            ModeShr: begin
               data_d  = {serial_in, data_q[N-1:1]};
               carry_d = data_q[0];
            end
            ModeRol: begin
               data_d  = {data_q[N-2:0], data_q[N-1]};
               carry_d = data_q[N-1];
            end
            ModeRor: begin
               data_d  = {data_q[0], data_q[N-1:1]};
               carry_d = data_q[0];
            end
            ModeInc: begin
               data_d  = data_q + One;
               carry_d = &data_q;
            end
            ModeDec: begin
               data_d  = data_q - One;
               carry_d = ~|data_q;
            end
            default: data_d = data_q;
         endcase
      end
   end

   // Reset wins over enable/mode and discards the operation of that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= ResetVal;
         carry_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         carry_q <= carry_d;
      end
   end

   assign data_out  = data_q;
   assign carry_out = carry_q;
   assign zero      = ~|data_q;

endmodule

// File: tb/tb_universal_nbit_register.sv
// Directed self-checking bench for universal_nbit_register (N=8).
// Two instances differ only in RESET_VALUE and share all stimulus.
module tb_universal_nbit_register;

   localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
   localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] mode = HOLD;
   logic [7:0] data_in = '0;
   logic [7:0] load_mask = '0;
   logic       serial_in = 1'b0;
   logic [7:0] dout_a, dout_z;
   logic       carry_a, carry_z, zero_a, zero_z;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   universal_nbit_register #(.N(8), .RESET_VALUE(64'hA5)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .data_in(data_in),
      .load_mask(load_mask), .serial_in(serial_in), .data_out(dout_a),
      .carry_out(carry_a), .zero(zero_a)
   );

   universal_nbit_register #(.N(8), .RESET_VALUE(64'h0)) dut_z (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .data_in(data_in),
      .load_mask(load_mask), .serial_in(serial_in), .data_out(dout_z),
      .carry_out(carry_z), .zero(zero_z)
   );

   // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
   task automatic step(input logic en, input logic [2:0] md, input logic [7:0] din,
                       input logic [7:0] msk, input logic si);
      enable = en; mode = md; data_in = din; load_mask = msk; serial_in = si;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'hA5) begin failures++;
         $display("FAIL reset_data_a got=%h exp=a5", dout_a); end
      checks++; if (carry_a !== 1'b0) begin failures++;
         $display("FAIL reset_carry_a got=%b exp=0", carry_a); end
      checks++; if (zero_a !== 1'b0) begin failures++;
         $display("FAIL reset_zero_a got=%b exp=0", zero_a); end
      checks++; if (dout_z !== 8'h00) begin failures++;
         $display("FAIL reset_data_z got=%h exp=00", dout_z); end
      checks++; if (zero_z !== 1'b1) begin failures++;
         $display("FAIL reset_zero_z got=%b exp=1", zero_z); end
      reset = 1'b0;
   endtask

   task automatic test_masked_load();
      step(1'b1, LOAD, 8'h00, 8'hFF, 1'b1);
      checks++; if (dout_a !== 8'h00 || zero_a !== 1'b1) begin failures++;
         $display("FAIL load_full got=%h zero=%b exp=00 zero=1", dout_a, zero_a); end
      step(1'b1, LOAD, 8'hFF, 8'h0F, 1'b1);
      checks++; if (dout_a !== 8'h0F || carry_a !== 1'b0) begin failures++;
         $display("FAIL load_mask0f got=%h c=%b exp=0f c=0", dout_a, carry_a); end
      step(1'b1, LOAD, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'h0F || zero_a !== 1'b0) begin failures++;
         $display("FAIL load_mask00 got=%h zero=%b exp=0f zero=0", dout_a, zero_a); end
   endtask

   task automatic test_shifts();
      logic [2:0] md  [4] = '{SHL, SHR, ROR, ROL};
      logic       si  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] exd [4] = '{8'h02, 8'h81, 8'hC0, 8'h81};
      logic       exc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      step(1'b1, LOAD, 8'h81, 8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, md[i], 8'h00, 8'hFF, si[i]);
         checks++; if (dout_a !== exd[i] || carry_a !== exc[i]) begin failures++;
            $display("FAIL shift_%0d got=%h c=%b exp=%h c=%b", i, dout_a, carry_a,
                     exd[i], exc[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [2:0] md  [4] = '{INC, INC, DEC, DEC};
      logic [7:0] exd [4] = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
      logic       exc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic       exz [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      step(1'b1, LOAD, 8'hFE, 8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, md[i], 8'h55, 8'h00, 1'b1);
         checks++;
         if (dout_a !== exd[i] || carry_a !== exc[i] || zero_a !== exz[i]) begin
            failures++;
            $display("FAIL wrap_%0d got=%h c=%b z=%b exp=%h c=%b z=%b", i, dout_a, carry_a,
                     zero_a, exd[i], exc[i], exz[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] md  [3] = '{INC, DEC, INC};
      logic [7:0] exd [3] = '{8'h00, 8'hFF, 8'h00};
      step(1'b1, LOAD, 8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, md[i], 8'h00, 8'h00, 1'b0);
         checks++; if (dout_a !== exd[i] || carry_a !== 1'b1) begin failures++;
            $display("FAIL b2b_%0d got=%h c=%b exp=%h c=1", i, dout_a, carry_a, exd[i]); end
      end
   endtask

   task automatic test_hold();
      step(1'b1, LOAD, 8'h9E, 8'hFF, 1'b0);
      step(1'b1, SHL, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'h3C || carry_a !== 1'b1) begin failures++;
         $display("FAIL hold_setup got=%h c=%b exp=3c c=1", dout_a, carry_a); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, INC, 8'hFF, 8'hFF, 1'b1);
         checks++; if (dout_a !== 8'h3C || carry_a !== 1'b0) begin failures++;
            $display("FAIL hold_%0d got=%h c=%b exp=3c c=0", i, dout_a, carry_a); end
      end
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'h3D || carry_a !== 1'b0) begin failures++;
         $display("FAIL hold_resume got=%h c=%b exp=3d c=0", dout_a, carry_a); end
   endtask

   task automatic test_reset_mid_count();
      logic [7:0] exp_v;
      step(1'b1, LOAD, 8'h00, 8'hFF, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, INC, 8'h00, 8'h00, 1'b0);
         exp_v = 8'(i);
         checks++; if (dout_a !== exp_v) begin failures++;
            $display("FAIL count_%0d got=%h exp=%h", i, dout_a, exp_v); end
      end
      reset = 1'b1;
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      reset = 1'b0;
      checks++; if (dout_a !== 8'hA5 || carry_a !== 1'b0) begin failures++;
         $display("FAIL midreset_a got=%h c=%b exp=a5 c=0", dout_a, carry_a); end
      checks++; if (dout_z !== 8'h00 || zero_z !== 1'b1) begin failures++;
         $display("FAIL midreset_z got=%h z=%b exp=00 z=1", dout_z, zero_z); end
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'hA6) begin failures++;
         $display("FAIL resume_1 got=%h exp=a6", dout_a); end
      step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      checks++; if (dout_a !== 8'hA7 || dout_z !== 8'h02) begin failures++;
         $display("FAIL resume_2 got=%h/%h exp=a7/02", dout_a, dout_z); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_masked_load();
      test_shifts();
      test_wrap();
      test_back_to_back();
      test_hold();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
